vga_scan_timing: RTL

- Downstream stage of the RGB pixel source. Generates the VGA pixel clock, hsync/vsync and blanking for the ADV7123 DAC.
- Issues per-pixel fetch coordinates (pix_x, pix_y, pix_req) to the pixel source.
- Registers the returned RGB, aligned with the delayed sync and blank signals, onto the VGA pins.
- Default mode: 640x480@60 Hz from a 50 MHz FPGA_Clock, divided by 2.

---
 rtl/vga_scan_timing.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vga_scan_timing.sv
// VGA scan timing: pixel-clock divider, h/v scan counters, fetch coordinate issue,
// and a FETCH_LAT-deep control delay that re-aligns sync/blank with returned RGB.
module vga_scan_timing #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int FETCH_LAT = 1
) (
  input  logic       FPGA_Clock,
  input  logic       FPGA_Reset_n,
  input  logic [7:0] pix_R,
  input  logic [7:0] pix_G,
  input  logic [7:0] pix_B,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_req,
  output logic       frame_start,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_Clock
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } scan_t;

  localparam scan_t SCAN_BLANK = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [DW-1:0] div_cnt, div_nxt;
  logic          pix_en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  scan_t         cur;
  scan_t [FETCH_LAT-1:0] ctl_pipe;

  assign pix_en     = (div_cnt == DIV_LAST);
  assign div_nxt    = pix_en ? '0 : div_cnt + 1'b1;
  assign VGA_SYNC_N = 1'b0;

  // Decode from the pre-increment counters: this is the pixel issued at this pix_en.
  assign cur = '{active: (h_cnt < H_VIS) && (v_cnt < V_VIS),
                 hs:     !((h_cnt >= HS_BEG) && (h_cnt < HS_END)),
                 vs:     !((v_cnt >= VS_BEG) && (v_cnt < VS_END))};

  // VGA_Clock tracks the new div_cnt so its falling edge lands on the output-update edge.
  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_n) begin
    if (!FPGA_Reset_n) begin
      div_cnt   <= '0;
      VGA_Clock <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      VGA_Clock <= (div_nxt >= DIV_HALF);
    end
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_n) begin
    if (!FPGA_Reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_n) begin
    if (!FPGA_Reset_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        pix_req <= cur.active;
        pix_x   <= cur.active ? 10'(h_cnt) : '0;
        pix_y   <= cur.active ? 10'(v_cnt) : '0;
      end
    end
  end

  // Control delay matches the pixel source's fetch latency; output regs close the last stage.
  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_n) begin
    if (!FPGA_Reset_n) begin
      ctl_pipe    <= {FETCH_LAT{SCAN_BLANK}};
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      ctl_pipe[0] <= cur;
      for (int i = 1; i < FETCH_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
      VGA_HS      <= ctl_pipe[FETCH_LAT-1].hs;
      VGA_VS      <= ctl_pipe[FETCH_LAT-1].vs;
      VGA_BLANK_N <= ctl_pipe[FETCH_LAT-1].active;
      VGA_R       <= ctl_pipe[FETCH_LAT-1].active ? pix_R : '0;
      VGA_G       <= ctl_pipe[FETCH_LAT-1].active ? pix_G : '0;
      VGA_B       <= ctl_pipe[FETCH_LAT-1].active ? pix_B : '0;
    end
  end

endmodule
